nios_ii_button_debounce: RTL
============================

// Module: nios_ii_button_debounce
//
// PURPOSE
// Cleans the raw push-button inputs before they reach the button PIO. Each
// bit is passed through a synchroniser and then a per-bit debounce counter.
// btn_out drives the PIO in_port directly and updates only after the input
// has been stable for DEBOUNCE_CYCLES clocks. It sits between the board KEY
// pins and the PIO.
//
// PARAMETERS
// WIDTH           4       number of buttons
// SYNC_STAGES     2       synchroniser flops per bit (legal values >= 2)
// DEBOUNCE_CYCLES 500000  required stable clocks (10 ms @ 50 MHz); must be >= 2
// RESET_LEVEL     4'hF    reset value of the sync flops and btn_out (keys idle high)
// PRESSED_LEVEL   1'b0    raw/debounced level that means "pressed"
// CNT_W is a localparam equal to $clog2(DEBOUNCE_CYCLES). It is not overridable.
//
// PORTS
// clk         in   1      system clock
// reset_n     in   1      asynchronous active-low reset
// btn_raw     in   WIDTH  asynchronous button pins
// btn_out     out  WIDTH  debounced levels, same polarity as btn_raw; feeds PIO in_port
// press_pulse out  WIDTH  one-clock pressed strobe; present only with macro
//
// BEHAVIOUR
// Clocking and reset
// - One clock domain (clk). reset_n is asynchronous and active-low.
// - Reset: sync flops = RESET_LEVEL, btn_out = RESET_LEVEL, counters = 0,
//   press_pulse = 0.
// - On deassertion there is no spurious transition while the pins are idle.
// - Reset asserted mid-count: the count is abandoned and btn_out returns to
//   RESET_LEVEL immediately.
//
// Synchroniser
// - btn_raw[i] passes through SYNC_STAGES flops. The last stage is s[i].
//
// Per-bit counter (the bits are fully independent)
// - If s[i] == btn_out[i]: cnt[i] <= 0.
// - Else, if cnt[i] == DEBOUNCE_CYCLES-1: btn_out[i] <= s[i] and cnt[i] <= 0.
// - Else: cnt[i] <= cnt[i] + 1.
// - The counter never wraps. It is bounded by the compare above.
//
// Latency and glitch filtering
// - A clean raw edge changes btn_out exactly SYNC_STAGES+DEBOUNCE_CYCLES rising
//   edges after the first edge that samples it.
// - A bounce shorter than DEBOUNCE_CYCLES clocks at s[i] restarts the count.
//   btn_out does not change.
// - Simultaneous changes on several bits are each timed independently.
//
// Outputs
// - btn_out is registered. There is no combinational path from btn_raw.
//
// CONFIGURATION
// Macro NIOS_II_BUTTON_DEBOUNCE_PULSE_EN:
// - Defined:
//   - The press_pulse port exists.
//   - press_pulse[i] = 1 for exactly one clock, registered, in the cycle after
//     btn_out[i] changes to PRESSED_LEVEL.
//   - A release never pulses.
// - Undefined:
//   - The press_pulse port and its logic are absent.
//   - btn_out behaviour is identical in both builds.
//
// TESTING (sim with DEBOUNCE_CYCLES=8, SYNC_STAGES=2, WIDTH=4)
// 1. Reset with btn_raw=4'hF, release reset, then run 50 clocks
//    -> btn_out=4'hF throughout; press_pulse=0.
// 2. btn_raw[0] 1->0, held clean
//    -> btn_out[0]=0 exactly 10 edges later;
//    -> with macro, press_pulse=4'b0001 for one clock on the next edge.
// 3. btn_raw[1] low for 5 clocks, then high again
//    -> btn_out stays 4'hF;
//    -> a low for 8 clocks is accepted.
// 4. Bounce: btn_raw[2] toggles every 3 clocks for 30 clocks, then settles low
//    -> one transition only, 10 edges after settling;
//    -> one press pulse only.
// 5. Assert reset_n while cnt[3]=6 mid-press, then release it with the pin
//    still low
//    -> btn_out immediately 4'hF;
//    -> after release, btn_out[3]=0 after a full 10 edges.
// 6. btn_raw 4'hF -> 4'h0 in one cycle
//    -> all bits fall on the same edge;
//    -> press_pulse=4'hF once; release back to 4'hF gives no pulse.

Source files
------------

// File: rtl/nios_ii_button_debounce.sv
// Two-flop synchroniser plus per-bit stable-time debounce for board push buttons; optional press strobe under NIOS_II_BUTTON_DEBOUNCE_PULSE_EN.
// Latency: SYNC_STAGES + DEBOUNCE_CYCLES clocks from a clean pin edge to btn_out; press_pulse one clock after that.
// Backpressure: none; free-running, the consumer (PIO in_port) samples btn_out every clock.
module nios_ii_button_debounce #(
    parameter int               WIDTH           = 4,
    parameter int               SYNC_STAGES     = 2,
    parameter int               DEBOUNCE_CYCLES = 500000,
    parameter logic [WIDTH-1:0] RESET_LEVEL     = {WIDTH{1'b1}},
    parameter logic             PRESSED_LEVEL   = 1'b0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] btn_raw,
    output logic [WIDTH-1:0] btn_out
`ifdef NIOS_II_BUTTON_DEBOUNCE_PULSE_EN
    ,
    output logic [WIDTH-1:0] press_pulse
`endif
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    if (SYNC_STAGES < 2 || DEBOUNCE_CYCLES < 2 || $bits(PRESSED_LEVEL) != 1) begin : g_bad_param
        $error("nios_ii_button_debounce: illegal parameter combination");
    end

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [CNT_W-1:0] cnt_q  [WIDTH];
    logic [CNT_W-1:0] cnt_d  [WIDTH];
    logic [WIDTH-1:0] btn_q;
    logic [WIDTH-1:0] btn_d;
    logic [WIDTH-1:0] sync_s;

    assign sync_s  = sync_q[SYNC_STAGES-1];
    assign btn_out = btn_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                sync_q[k] <= RESET_LEVEL;
            end
        end else begin
            sync_q[0] <= btn_raw;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                sync_q[k] <= sync_q[k-1];
            end
        end
    end

    // Any sample that agrees with the current output restarts the stable-time count.
    always_comb begin
        btn_d = btn_q;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_d[i] = '0;
            if (sync_s[i] != btn_q[i]) begin
                if (cnt_q[i] == CNT_MAX) begin
                    btn_d[i] = sync_s[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            btn_q <= RESET_LEVEL;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            btn_q <= btn_d;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

`ifdef NIOS_II_BUTTON_DEBOUNCE_PULSE_EN
    logic [WIDTH-1:0] btn_prev_q;
    logic [WIDTH-1:0] pulse_q;
    logic [WIDTH-1:0] now_pressed;
    logic [WIDTH-1:0] was_pressed;

    assign now_pressed = btn_q ~^ {WIDTH{PRESSED_LEVEL}};
    assign was_pressed = btn_prev_q ~^ {WIDTH{PRESSED_LEVEL}};
    assign press_pulse = pulse_q;

    // Edge detect on the registered output, so the strobe lands one clock after btn_out moves.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            btn_prev_q <= RESET_LEVEL;
            pulse_q    <= '0;
        end else begin
            btn_prev_q <= btn_q;
            pulse_q    <= now_pressed & ~was_pressed;
        end
    end
`endif

endmodule
